// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM states, default width, counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_add.sv
// full_add: one-bit combinational full adder cell; zero latency, no flow control.
module full_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first A+B+Cin through a single full_add cell; Ovf port only with SERIAL_ADDER_OVF_EN.
// Latency WIDTH cycles from accepted start to valid; result held until ack, start ignored while busy.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             valid,
  input  logic             ack
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_w;
  logic             fa_s;
  logic             fa_c;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_add u_full_add (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  // The newest sum bit lands in the MSB; the accumulator only needs the lower WIDTH-1 bits.
  assign shift_w = {fa_s, acc_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = shift_w[WIDTH-1:1];
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = shift_w;
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_c;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = (state_q == IDLE);
  assign valid = (state_q == DONE);
  assign Sum   = sum_q;
  assign Cout  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign Ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: random and directed additions checked against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         ack = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] sum;
  logic         ready, valid, cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           rises[$];
  logic         valid_prev = 1'b0;
  logic [W-1:0] held_sum = '0;
  logic         held_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ready (ready),
    .A     (a),
    .B     (b),
    .Cin   (cin),
    .Sum   (sum),
    .Cout  (cout),
    .valid (valid),
    .ack   (ack)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .Ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int to_signed(input logic [W-1:0] x);
    return (int'(x) >= 2 ** (W - 1)) ? int'(x) - 2 ** W : int'(x);
  endfunction

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input int acc);
    exp_t e;
    int   total;
    int   stotal;
    total  = int'(x) + int'(y) + int'(c);
    stotal = to_signed(x) + to_signed(y) + int'(c);
    e.sum  = W'(total % (2 ** W));
    e.cout = (total >= 2 ** W);
    e.ovf  = (stotal > 2 ** (W - 1) - 1) || (stotal < -(2 ** (W - 1)));
    e.acc  = acc;
    return e;
  endfunction

  // Monitor: pops on each fresh result and watches held outputs.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ready && valid) check("ready_valid_exclusive", 64'(ready & valid), 0);
      if (valid && !valid_prev) begin
        rises.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sum", 64'(sum), 64'(e.sum));
          check("cout", 64'(cout), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
          check("ovf", 64'(ovf), 64'(e.ovf));
`endif
          check("latency", 64'(cyc - e.acc), 64'(W));
          held_sum  = e.sum;
          held_cout = e.cout;
        end
      end else if (valid) begin
        check("sum_stable", 64'(sum), 64'(held_sum));
        check("cout_stable", 64'(cout), 64'(held_cout));
      end
    end
    valid_prev = valid;
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    @(negedge clk);
    wait_ready();
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    sb.push_back(model(x, y, c, cyc + 1));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_ack(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 4 * W);
    if (!valid) begin
      check("valid_timeout", 0, 1);
    end else begin
      repeat (d) @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
      check("ready_after_ack", 64'(ready), 1);
      check("valid_after_ack", 64'(valid), 0);
      check("sum_held_idle", 64'(sum), 64'(held_sum));
      check("cout_held_idle", 64'(cout), 64'(held_cout));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(ready), 1);
    check({tag, "_valid"}, 64'(valid), 0);
    check({tag, "_sum"}, 64'(sum), 0);
    check({tag, "_cout"}, 64'(cout), 0);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_ready", 64'(ready), 1);
      check("idle_valid", 64'(valid), 0);
    end
    check_reset_vals("idle_end");

    issue(8'h3C, 8'h05, 1'b0); finish_ack(3);
    issue(8'hFF, 8'h01, 1'b0); finish_ack(1);
    issue(8'hFF, 8'h01, 1'b1); finish_ack(0);
    issue(8'h7F, 8'h01, 1'b0); finish_ack(2);

    // start and ack held through SHIFT with operands changing underneath
    @(negedge clk);
    wait_ready();
    a = 8'h5A; b = 8'h33; cin = 1'b1; start = 1'b1;
    sb.push_back(model(8'h5A, 8'h33, 1'b1, cyc + 1));
    @(posedge clk);
    repeat (5) begin
      #1;
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      ack = 1'b1;
      @(posedge clk);
    end
    #1 start = 1'b0;
    ack = 1'b0;
    finish_ack(3);

    // reset while bit 4 is being processed
    issue(8'hA5, 8'h6E, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    sb.delete();
    rst = 1'b1;
    #1 check_reset_vals("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(8'h10, 8'h20, 1'b0); finish_ack(1);

    // back-to-back with ack in the first valid cycle
    rises.delete();
    issue(8'h11, 8'h22, 1'b0); finish_ack(0);
    issue(8'hC8, 8'h64, 1'b1); finish_ack(0);
    if (rises.size() == 2) check("b2b_period", 64'(rises[1] - rises[0]), 64'(W + 2));
    else check("b2b_count", 64'(rises.size()), 2);

    for (int i = 0; i < 25; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      finish_ack($urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
